// File: rtl/dino_jump_if.sv
// Signal bundle between the game logic and the dino vertical-motion controller.
// The controller uses the slave side; the game logic or testbench uses the master side.
interface dino_jump_if #(
    parameter int Y_WIDTH = 8
);
    logic               btn_state;
    logic               tick;
    logic               halt;
    logic [Y_WIDTH-1:0] height;
    logic               airborne;
    logic               jump_start;
    logic               land;

    modport master (
        output btn_state, tick, halt,
        input  height, airborne, jump_start, land
    );

    modport slave (
        input  btn_state, tick, halt,
        output height, airborne, jump_start, land
    );
endinterface

// File: rtl/dino_jump_ctrl.sv
// Dino jump controller: press edge detect, tick-driven IDLE/ASCEND/DESCEND motion with gravity.
// Optional build macro JUMP_BUFFER_EN lets a press made while descending relaunch on the landing tick.
module dino_jump_ctrl #(
    parameter int Y_WIDTH = 8,
    parameter int V_WIDTH = 5,
    parameter int V0      = 10,
    parameter int GRAVITY = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    dino_jump_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ASCEND, DESCEND} state_t;

    localparam int                 SW       = (Y_WIDTH > V_WIDTH) ? Y_WIDTH : V_WIDTH;
    localparam logic [V_WIDTH-1:0] V_LAUNCH = V_WIDTH'(V0);
    localparam logic [V_WIDTH-1:0] V_GRAV   = V_WIDTH'(GRAVITY);
    localparam logic [Y_WIDTH:0]   Y_MAX    = {1'b0, {Y_WIDTH{1'b1}}};
    localparam logic [V_WIDTH:0]   V_MAX    = {1'b0, {V_WIDTH{1'b1}}};

    state_t             state;
    logic               btn_q;
    logic               pending;
    logic [V_WIDTH-1:0] vel;
    logic [Y_WIDTH-1:0] height;
    logic               airborne;
    logic               jump_start;
    logic               land;

    logic               press;
    logic [Y_WIDTH:0]   rise_sum;
    logic [Y_WIDTH-1:0] rise_height;
    logic [V_WIDTH:0]   fall_sum;
    logic [V_WIDTH-1:0] fall;
    logic               lands;
    logic               buffered;

    // Next-step arithmetic is one bit wider than its register so saturation can be detected.
    always_comb begin
        press       = bus.btn_state & ~btn_q;
        rise_sum    = {1'b0, height} + (Y_WIDTH+1)'(vel);
        rise_height = (rise_sum > Y_MAX) ? Y_MAX[Y_WIDTH-1:0] : rise_sum[Y_WIDTH-1:0];
        fall_sum    = {1'b0, vel} + {1'b0, V_GRAV};
        fall        = (fall_sum > V_MAX) ? V_MAX[V_WIDTH-1:0] : fall_sum[V_WIDTH-1:0];
        lands       = SW'(fall) >= SW'(height);
`ifdef JUMP_BUFFER_EN
        buffered    = pending | press;
`else
        buffered    = 1'b0;
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            btn_q      <= 1'b0;
            pending    <= 1'b0;
            vel        <= '0;
            height     <= '0;
            airborne   <= 1'b0;
            jump_start <= 1'b0;
            land       <= 1'b0;
        end else begin
            btn_q      <= bus.btn_state;
            jump_start <= 1'b0;
            land       <= 1'b0;
            if (bus.halt) begin
                pending <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.tick && (pending || press)) begin
                            state      <= ASCEND;
                            vel        <= V_LAUNCH;
                            pending    <= 1'b0;
                            jump_start <= 1'b1;
                            airborne   <= 1'b1;
                        end else if (press) begin
                            pending <= 1'b1;
                        end
                    end
                    ASCEND: begin
                        if (bus.tick) begin
                            height <= rise_height;
                            if (vel <= V_GRAV) begin
                                vel   <= '0;
                                state <= DESCEND;
                            end else begin
                                vel <= vel - V_GRAV;
                            end
                        end
                    end
                    DESCEND: begin
`ifdef JUMP_BUFFER_EN
                        if (press) pending <= 1'b1;
`endif
                        if (bus.tick) begin
                            if (lands) begin
                                height <= '0;
                                land   <= 1'b1;
                                // A buffered press skips IDLE so the dino never appears grounded.
                                if (buffered) begin
                                    state      <= ASCEND;
                                    vel        <= V_LAUNCH;
                                    pending    <= 1'b0;
                                    jump_start <= 1'b1;
                                end else begin
                                    state    <= IDLE;
                                    vel      <= '0;
                                    pending  <= 1'b0;
                                    airborne <= 1'b0;
                                end
                            end else begin
                                height <= height - Y_WIDTH'(fall);
                                vel    <= fall;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.height     = height;
    assign bus.airborne   = airborne;
    assign bus.jump_start = jump_start;
    assign bus.land       = land;
endmodule
